icache_direct: RTL and testbench

- Direct-mapped instruction cache between the instruction fetcher and the memory controller's instruction port.
- Serves fetch hits with one-cycle latency.
- On a miss, issues a single 32-bit word request to the memory controller, fills the line, and returns the instruction.
- Pipeline flush (clear) aborts an outstanding miss; it does not invalidate stored lines.

---
 rtl/icache_direct_if.sv | 37 +++
 rtl/icache_direct.sv | 175 +++++++++++++++++
 tb/tb_icache_direct.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
//   Bundles the fetch-side and memory-side handshake of icache_direct.
//
//   Fetch side : if_en_i, if_addr_i  -> cache
//                if_valid_o, if_inst_o <- cache
//   Memory side: mem_en_o, mem_addr_o <- cache (request to controller)
//                mem_en_i, mem_data_i -> cache (controller done + data)
//
//   Modports:
//     slave  - the cache itself
//     master - whatever sits around the cache (fetcher + memory controller)
//
//   ADDR_W must match the ADDR_W of the icache_direct instance it connects to.
// ---------------------------------------------------------------------------
interface icache_direct_if #(
    parameter int ADDR_W = 32
);
    logic              if_en_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_valid_o;
    logic [31:0]       if_inst_o;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_en_i;
    logic [31:0]       mem_data_i;

    modport slave (
        input  if_en_i, if_addr_i, mem_en_i, mem_data_i,
        output if_valid_o, if_inst_o, mem_en_o, mem_addr_o
    );

    modport master (
        output if_en_i, if_addr_i, mem_en_i, mem_data_i,
        input  if_valid_o, if_inst_o, mem_en_o, mem_addr_o
    );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped instruction cache, one 32-bit word per line. Hits return on
//   the next edge; misses issue a single word request to the memory
//   controller, fill the line and return the word on the edge after the
//   controller's done pulse. clear aborts a pending miss without touching
//   stored lines.
//
//   Ports:
//     clk_in   - clock
//     rst_in   - asynchronous active-low reset (clears all valid bits)
//     rdy_in   - global enable; low freezes every register and the array
//     clear    - synchronous flush; aborts the pending miss
//     bus      - icache_direct_if.slave (fetch + memory handshake)
//     hit_cnt_o / miss_cnt_o - saturating performance counters, present
//                only when ICACHE_PERF_EN is defined
//
//   Optional feature macro: ICACHE_PERF_EN
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    icache_direct_if.slave        bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       memAddr_q, memAddr_d;
    logic [31:0]             inst_q, inst_d;
    logic                    ifValid_q, ifValid_d;
    logic [INDEX_BITS-1:0]   missIdx_q, missIdx_d;
    logic [TAG_W-1:0]        missTag_q, missTag_d;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES];

    logic [INDEX_BITS-1:0]   reqIdx;
    logic [TAG_W-1:0]        reqTag;
    logic                    lookupHit;
    logic                    fillEn;
    logic                    hitAccept;
    logic                    missStart;

    assign reqIdx    = bus.if_addr_i[INDEX_BITS+1:2];
    assign reqTag    = bus.if_addr_i[ADDR_W-1:INDEX_BITS+2];
    assign lookupHit = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);

    // Request drops in the same cycle as the done pulse so the controller
    // never sees a second request when it returns to idle.
    assign bus.mem_en_o   = (state_q == MISS) && !bus.mem_en_i;
    assign bus.mem_addr_o = memAddr_q;
    assign bus.if_valid_o = ifValid_q;
    assign bus.if_inst_o  = inst_q;

    // Next-state and datapath decisions. clear outranks everything: it
    // returns to IDLE and swallows both a same-cycle fetch and a same-cycle
    // memory response.
    always_comb begin
        state_d   = state_q;
        memAddr_d = memAddr_q;
        inst_d    = inst_q;
        ifValid_d = 1'b0;
        missIdx_d = missIdx_q;
        missTag_d = missTag_q;
        fillEn    = 1'b0;
        hitAccept = 1'b0;
        missStart = 1'b0;

        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.if_en_i) begin
                        if (lookupHit) begin
                            inst_d    = data_q[reqIdx];
                            ifValid_d = 1'b1;
                            hitAccept = 1'b1;
                        end else begin
                            memAddr_d = bus.if_addr_i & WORD_MASK;
                            missIdx_d = reqIdx;
                            missTag_d = reqTag;
                            state_d   = MISS;
                            missStart = 1'b1;
                        end
                    end
                end
                MISS: begin
                    if (bus.mem_en_i) begin
                        fillEn    = 1'b1;
                        inst_d    = bus.mem_data_i;
                        ifValid_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            endcase
        end
    end

    // Control registers and the valid bits; these are the only state that
    // reset has to clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            memAddr_q <= '0;
            inst_q    <= '0;
            ifValid_q <= 1'b0;
            missIdx_q <= '0;
            missTag_q <= '0;
            valid_q   <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            memAddr_q <= memAddr_d;
            inst_q    <= inst_d;
            ifValid_q <= ifValid_d;
            missIdx_q <= missIdx_d;
            missTag_q <= missTag_d;
            if (fillEn) begin
                valid_q[missIdx_q] <= 1'b1;
            end
        end
    end

    // Tag and data storage is never reset; a line is only trusted once its
    // valid bit is set by a fill.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fillEn) begin
            tag_q[missIdx_q]  <= missTag_q;
            data_q[missIdx_q] <= bus.mem_data_i;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hitCnt_q;
    logic [31:0] missCnt_q;

    // Saturating counters; untouched by clear, frozen by rdy_in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (rdy_in) begin
            if (hitAccept && (hitCnt_q != 32'hFFFF_FFFF)) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if (missStart && (missCnt_q != 32'hFFFF_FFFF)) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//   Directed, table-driven bench for icache_direct (INDEX_BITS=8, ADDR_W=32),
//   plus hand-written sequences for rdy_in freeze and asynchronous reset in
//   the middle of a miss. Performance counter checks are compiled in only
//   when ICACHE_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_icache_direct;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;

    always #5 clk_in = ~clk_in;

    icache_direct_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
`endif

    icache_direct #(
        .INDEX_BITS (8),
        .ADDR_W     (32)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .bus        (bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt_o  (hitCnt),
        .miss_cnt_o (missCnt)
`endif
    );

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        memEn;
        logic [31:0] memData;
        logic        clr;
        logic        expMemEn;
        logic        expValid;
        logic [31:0] expInst;
        logic [31:0] expMemAddr;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic addVec(input logic en, input logic [31:0] addr,
                          input logic memEn, input logic [31:0] memData,
                          input logic clr, input logic expMemEn,
                          input logic expValid, input logic [31:0] expInst,
                          input logic [31:0] expMemAddr);
        vec_t v;
        v.en = en; v.addr = addr; v.memEn = memEn; v.memData = memData;
        v.clr = clr; v.expMemEn = expMemEn; v.expValid = expValid;
        v.expInst = expInst; v.expMemAddr = expMemAddr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic en, input logic [31:0] addr,
                               input logic memEn, input logic [31:0] memData,
                               input logic clr);
        bus.if_en_i    = en;
        bus.if_addr_i  = addr;
        bus.mem_en_i   = memEn;
        bus.mem_data_i = memData;
        clear          = clr;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one row (just after an edge), check the combinational request
    // before the next edge, then check the registered outputs after it.
    task automatic applyStimulus(input vec_t v, input int row);
        driveInputs(v.en, v.addr, v.memEn, v.memData, v.clr);
        #2;
        checkOutput($sformatf("row%0d mem_en_o", row), {31'b0, bus.mem_en_o}, {31'b0, v.expMemEn});
        tick();
        checkOutput($sformatf("row%0d if_valid_o", row), {31'b0, bus.if_valid_o}, {31'b0, v.expValid});
        checkOutput($sformatf("row%0d if_inst_o", row), bus.if_inst_o, v.expInst);
        checkOutput($sformatf("row%0d mem_addr_o", row), bus.mem_addr_o, v.expMemAddr);
    endtask

    initial begin
        //     en  addr           mE  memData         clr pre v  inst           memAddr
        // cold miss, then hit
        addVec(1, 32'h0000_1004, 0, 32'h0,          0,  0,  0, 32'h0,          32'h1004);
        addVec(0, 32'h0,         0, 32'h0,          0,  1,  0, 32'h0,          32'h1004);
        addVec(0, 32'h0,         1, 32'h00A0_0093,  0,  0,  1, 32'h00A0_0093,  32'h1004);
        addVec(1, 32'h0000_1004, 0, 32'h0,          0,  0,  1, 32'h00A0_0093,  32'h1004);
        addVec(0, 32'h0,         0, 32'h0,          0,  0,  0, 32'h00A0_0093,  32'h1004);
        // conflict eviction on index 1
        addVec(1, 32'h0000_2004, 0, 32'h0,          0,  0,  0, 32'h00A0_0093,  32'h2004);
        addVec(0, 32'h0,         0, 32'h0,          0,  1,  0, 32'h00A0_0093,  32'h2004);
        addVec(0, 32'h0,         1, 32'h1234_5678,  0,  0,  1, 32'h1234_5678,  32'h2004);
        addVec(1, 32'h0000_1004, 0, 32'h0,          0,  0,  0, 32'h1234_5678,  32'h1004);
        addVec(0, 32'h0,         1, 32'h00A0_0093,  0,  0,  1, 32'h00A0_0093,  32'h1004);
        // preload 0x0, 0x4, 0x8
        addVec(1, 32'h0000_0000, 0, 32'h0,          0,  0,  0, 32'h00A0_0093,  32'h0);
        addVec(0, 32'h0,         1, 32'h1111_1111,  0,  0,  1, 32'h1111_1111,  32'h0);
        addVec(1, 32'h0000_0004, 0, 32'h0,          0,  0,  0, 32'h1111_1111,  32'h4);
        addVec(0, 32'h0,         1, 32'h2222_2222,  0,  0,  1, 32'h2222_2222,  32'h4);
        addVec(1, 32'h0000_0008, 0, 32'h0,          0,  0,  0, 32'h2222_2222,  32'h8);
        addVec(0, 32'h0,         1, 32'h3333_3333,  0,  0,  1, 32'h3333_3333,  32'h8);
        // back-to-back hits
        addVec(1, 32'h0000_0000, 0, 32'h0,          0,  0,  1, 32'h1111_1111,  32'h8);
        addVec(1, 32'h0000_0004, 0, 32'h0,          0,  0,  1, 32'h2222_2222,  32'h8);
        addVec(1, 32'h0000_0008, 0, 32'h0,          0,  0,  1, 32'h3333_3333,  32'h8);
        addVec(0, 32'h0,         0, 32'h0,          0,  0,  0, 32'h3333_3333,  32'h8);
        // clear drops a same-cycle hit request
        addVec(1, 32'h0000_0000, 0, 32'h0,          1,  0,  0, 32'h3333_3333,  32'h8);
        // clear mid-miss discards the response
        addVec(1, 32'h0000_3000, 0, 32'h0,          0,  0,  0, 32'h3333_3333,  32'h3000);
        addVec(0, 32'h0,         0, 32'h0,          0,  1,  0, 32'h3333_3333,  32'h3000);
        addVec(0, 32'h0,         1, 32'hDEAD_BEEF,  1,  0,  0, 32'h3333_3333,  32'h3000);
        addVec(0, 32'h0,         0, 32'h0,          0,  0,  0, 32'h3333_3333,  32'h3000);
        addVec(1, 32'h0000_3000, 0, 32'h0,          0,  0,  0, 32'h3333_3333,  32'h3000);
        addVec(0, 32'h0,         0, 32'h0,          0,  1,  0, 32'h3333_3333,  32'h3000);
        addVec(0, 32'h0,         1, 32'h0BAD_F00D,  0,  0,  1, 32'h0BAD_F00D,  32'h3000);
        addVec(1, 32'h0000_3000, 0, 32'h0,          0,  0,  1, 32'h0BAD_F00D,  32'h3000);
        addVec(0, 32'h0,         0, 32'h0,          0,  0,  0, 32'h0BAD_F00D,  32'h3000);

        rst_in = 1'b0;
        rdy_in = 1'b1;
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        tick();
        checkOutput("reset if_valid_o", {31'b0, bus.if_valid_o}, 32'h0);
        checkOutput("reset if_inst_o", bus.if_inst_o, 32'h0);
        checkOutput("reset mem_addr_o", bus.mem_addr_o, 32'h0);
        checkOutput("reset mem_en_o", {31'b0, bus.mem_en_o}, 32'h0);
`ifdef ICACHE_PERF_EN
        checkOutput("reset hit_cnt_o", hitCnt, 32'h0);
        checkOutput("reset miss_cnt_o", missCnt, 32'h0);
`endif
        rst_in = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // rdy_in low holds a pending if_valid_o pulse
        driveInputs(1, 32'h0000_3000, 0, 32'h0, 0);
        tick();
        checkOutput("freeze hit valid", {31'b0, bus.if_valid_o}, 32'h1);
        rdy_in = 1'b0;
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        tick();
        checkOutput("freeze valid held", {31'b0, bus.if_valid_o}, 32'h1);
        checkOutput("freeze inst held", bus.if_inst_o, 32'h0BAD_F00D);
        rdy_in = 1'b1;
        tick();
        checkOutput("freeze release valid", {31'b0, bus.if_valid_o}, 32'h0);

        // rdy_in low ignores a done pulse while in MISS
        driveInputs(1, 32'h0000_5000, 0, 32'h0, 0);
        tick();
        checkOutput("miss5000 mem_addr_o", bus.mem_addr_o, 32'h5000);
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        rdy_in = 1'b0;
        #1;
        checkOutput("frozen miss mem_en_o", {31'b0, bus.mem_en_o}, 32'h1);
        driveInputs(0, 32'h0, 1, 32'hCAFE_F00D, 0);
        #1;
        checkOutput("frozen done mem_en_o", {31'b0, bus.mem_en_o}, 32'h0);
        tick();
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        #1;
        checkOutput("still miss mem_en_o", {31'b0, bus.mem_en_o}, 32'h1);
        checkOutput("frozen done no valid", {31'b0, bus.if_valid_o}, 32'h0);
        checkOutput("frozen done inst", bus.if_inst_o, 32'h0BAD_F00D);

        // asynchronous reset mid-miss, mid-cycle
        rdy_in = 1'b1;
        rst_in = 1'b0;
        #1;
        checkOutput("areset if_valid_o", {31'b0, bus.if_valid_o}, 32'h0);
        checkOutput("areset if_inst_o", bus.if_inst_o, 32'h0);
        checkOutput("areset mem_addr_o", bus.mem_addr_o, 32'h0);
        checkOutput("areset mem_en_o", {31'b0, bus.mem_en_o}, 32'h0);
`ifdef ICACHE_PERF_EN
        checkOutput("areset hit_cnt_o", hitCnt, 32'h0);
        checkOutput("areset miss_cnt_o", missCnt, 32'h0);
`endif
        rdy_in = 1'b0;
        tick();
        rdy_in = 1'b1;
        tick();
        rst_in = 1'b1;

        // line 0x3000 was valid before reset; it must miss now
        driveInputs(1, 32'h0000_3000, 0, 32'h0, 0);
        tick();
        checkOutput("post-reset miss valid", {31'b0, bus.if_valid_o}, 32'h0);
        checkOutput("post-reset miss addr", bus.mem_addr_o, 32'h3000);
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        #1;
        checkOutput("post-reset mem_en_o", {31'b0, bus.mem_en_o}, 32'h1);
        driveInputs(0, 32'h0, 1, 32'h7777_7777, 0);
        tick();
        checkOutput("post-reset fill valid", {31'b0, bus.if_valid_o}, 32'h1);
        checkOutput("post-reset fill inst", bus.if_inst_o, 32'h7777_7777);
        driveInputs(1, 32'h0000_3000, 0, 32'h0, 0);
        tick();
        checkOutput("post-reset hit1", bus.if_inst_o, 32'h7777_7777);
        tick();
        checkOutput("post-reset hit2 valid", {31'b0, bus.if_valid_o}, 32'h1);
        driveInputs(0, 32'h0, 0, 32'h0, 0);
        tick();
        checkOutput("post-reset idle valid", {31'b0, bus.if_valid_o}, 32'h0);
`ifdef ICACHE_PERF_EN
        checkOutput("perf hit_cnt_o", hitCnt, 32'd2);
        checkOutput("perf miss_cnt_o", missCnt, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
